tt_um_div8: RTL and testbench

TT_UM_DIV8 -- requirements
Module: tt_um_div8

---
 rtl/tt_div8_pkg.sv | 11 +
 rtl/sub5_borrow.sv | 13 +
 rtl/tt_um_div8.sv | 88 ++++++++
 tb/tb_tt_um_div8.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/tt_div8_pkg.sv
// tt_div8_pkg: shared FSM state, operand widths and uio bit positions for the divider
package tt_div8_pkg;
  localparam int DW = 8;
  localparam int VW = 4;
  localparam int START_BIT = 4;
  localparam int SEL_BIT = 5;
  localparam int BUSY_BIT = 6;
  localparam int DONE_BIT = 7;
  localparam logic [7:0] UIO_OE = 8'b1100_0000;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
endpackage

// File: rtl/sub5_borrow.sv
// sub5_borrow: 5-bit trial subtraction with borrow out
//   a      : 5-bit minuend (partial remainder)
//   b      : 4-bit subtrahend, zero-extended
//   diff   : a - b, modulo 32
//   borrow : 1 when a < b
module sub5_borrow (
  input  logic [4:0] a,
  input  logic [3:0] b,
  output logic [4:0] diff,
  output logic       borrow
);
  assign {borrow, diff} = {1'b0, a} - {2'b00, b};
endmodule

// File: rtl/tt_um_div8.sv
// tt_um_div8: unsigned restoring divider, DW-bit dividend by VW-bit divisor, one quotient bit per cycle
//   clk, rst_n : clock, asynchronous active-low reset
//   ena        : enable, 0 freezes all state
//   ui_in      : dividend
//   uio_in     : [3:0] divisor, [4] start, [5] result select
//   uo_out     : quotient (select=0) or zero-extended remainder (select=1)
//   uio_out    : [6] busy, [7] done
//   uio_oe     : fixed output enables for busy/done
module tt_um_div8 #(
  parameter int DW = tt_div8_pkg::DW,
  parameter int VW = tt_div8_pkg::VW
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);
  import tt_div8_pkg::*;
  localparam int CW = $clog2(DW);
  state_t state;
  logic [DW-1:0] dvd, quo, res_q;
  logic [VW-1:0] dvs, rem, res_r, next_rem;
  logic [CW-1:0] cnt;
  logic start, start_q, armed, start_ev, busy, done, borrow;
  logic [VW:0] part, diff;
  logic unused;
  assign start = uio_in[START_BIT];
  // armed stays low after reset until start is seen low, so a start held through reset release cannot launch
  assign start_ev = start & ~start_q & armed;
  assign part = {rem, dvd[DW-1]};
  sub5_borrow u_sub (.a(part), .b(dvs), .diff(diff), .borrow(borrow));
  // when the divisor fits, the difference is below the divisor; otherwise the partial is below it, so both fit VW bits
  assign next_rem = borrow ? part[VW-1:0] : diff[VW-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      start_q <= 1'b0;
      armed <= 1'b0;
      dvd <= '0;
      dvs <= '0;
      rem <= '0;
      quo <= '0;
      cnt <= '0;
      res_q <= '0;
      res_r <= '0;
    end else if (ena) begin
      start_q <= start;
      armed <= armed | ~start;
      if (state != RUN && start_ev) begin
        state <= RUN;
        busy <= 1'b1;
        done <= 1'b0;
        dvd <= ui_in[DW-1:0];
        dvs <= uio_in[VW-1:0];
        rem <= '0;
        quo <= '0;
        cnt <= '0;
      end else if (state == RUN) begin
        dvd <= dvd << 1;
        rem <= next_rem;
        quo <= {quo[DW-2:0], ~borrow};
        cnt <= cnt + 1'b1;
        if (cnt == CW'(DW - 1)) begin
          state <= DONE;
          busy <= 1'b0;
          done <= 1'b1;
          res_q <= {quo[DW-2:0], ~borrow};
          // a zero divisor reports an all-ones remainder alongside the all-ones quotient
          res_r <= (dvs == '0) ? '1 : next_rem;
        end
      end
    end
  end
  assign uo_out = uio_in[SEL_BIT] ? 8'(res_r) : 8'(res_q);
  always_comb begin
    uio_out = 8'h00;
    uio_out[BUSY_BIT] = busy;
    uio_out[DONE_BIT] = done;
  end
  assign uio_oe = UIO_OE;
  assign unused = &{1'b0, uio_in[7:6], part[VW], diff[VW]};
endmodule

// File: tb/tb_tt_um_div8.sv
// tb_tt_um_div8: vector table, randomized and corner-sequence checks of tt_um_div8 against an arithmetic model
module tb_tt_um_div8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ena = 1'b1;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out, uio_out, uio_oe;
  int n_checks = 0;
  int n_fail = 0;

  tt_um_div8 dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [7:0] a, input logic [3:0] b);
    ui_in = a;
    uio_in[3:0] = b;
    uio_in[4] = 1'b1;
    tick();
    uio_in[4] = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (uio_out[6] && cyc < 40) begin
      cyc++;
      tick();
    end
  endtask

  task automatic read_result(output logic [7:0] q, output logic [7:0] r);
    uio_in[5] = 1'b0;
    #1 q = uo_out;
    uio_in[5] = 1'b1;
    #1 r = uo_out;
    uio_in[5] = 1'b0;
    #1;
  endtask

  function automatic logic [7:0] model_q(input logic [7:0] a, input logic [3:0] b);
    return (b == 0) ? 8'hFF : 8'(a / b);
  endfunction

  function automatic logic [3:0] model_r(input logic [7:0] a, input logic [3:0] b);
    return (b == 0) ? 4'hF : 4'(a % b);
  endfunction

  task automatic full_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                          input logic [7:0] eq, input logic [3:0] er);
    int cyc;
    logic [7:0] q, r;
    launch(a, b);
    check({tag, " busy after launch"}, int'(uio_out[7:6]), 1);
    wait_done(cyc);
    check({tag, " busy cycles"}, cyc, 8);
    check({tag, " done/busy"}, int'(uio_out), 8'h80);
    read_result(q, r);
    check({tag, " quotient"}, int'(q), int'(eq));
    check({tag, " remainder"}, int'(r), int'(er));
  endtask

  initial begin
    vec_t vecs[8];
    int cyc;
    logic [7:0] q, r, a;
    logic [3:0] b;
    vecs[0] = '{8'd200, 4'd7, 8'd28, 4'd4};
    vecs[1] = '{8'd255, 4'd15, 8'd17, 4'd0};
    vecs[2] = '{8'd5, 4'd9, 8'd0, 4'd5};
    vecs[3] = '{8'h37, 4'd0, 8'hFF, 4'hF};
    vecs[4] = '{8'd100, 4'd3, 8'd33, 4'd1};
    vecs[5] = '{8'd99, 4'd10, 8'd9, 4'd9};
    vecs[6] = '{8'd0, 4'd5, 8'd0, 4'd0};
    vecs[7] = '{8'd15, 4'd1, 8'd15, 4'd0};

    #3;
    check("reset uo_out", int'(uo_out), 0);
    check("reset uio_out", int'(uio_out), 0);
    check("uio_oe", int'(uio_oe), 8'hC0);
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    check("idle uio_out", int'(uio_out), 0);

    foreach (vecs[i]) full_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r);

    for (int i = 0; i < 30; i++) begin
      a = 8'($urandom_range(0, 255));
      b = 4'($urandom_range(0, 15));
      full_div($sformatf("rnd%0d %0d/%0d", i, a, b), a, b, model_q(a, b), model_r(a, b));
    end

    // second start and operand change mid-run are ignored
    launch(8'd200, 4'd7);
    tick();
    tick();
    ui_in = 8'h11;
    uio_in[3:0] = 4'd3;
    uio_in[4] = 1'b1;
    tick();
    uio_in[4] = 1'b0;
    wait_done(cyc);
    check("restart ignored busy", cyc + 3, 8);
    read_result(q, r);
    check("restart ignored q", int'(q), 28);
    check("restart ignored r", int'(r), 4);

    // enable low freezes the run
    launch(8'd200, 4'd7);
    tick();
    tick();
    tick();
    ena = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("ena freeze busy", int'(uio_out[7:6]), 1);
    ena = 1'b1;
    wait_done(cyc);
    check("ena freeze remaining", cyc, 5);
    read_result(q, r);
    check("ena freeze q", int'(q), 28);
    check("ena freeze r", int'(r), 4);

    // back-to-back: start in DONE relaunches at once
    full_div("b2b first", 8'd100, 4'd3, 8'd33, 4'd1);
    full_div("b2b second", 8'd99, 4'd10, 8'd9, 4'd9);

    // reset mid-run with start held across release
    launch(8'd200, 4'd7);
    tick();
    tick();
    tick();
    uio_in[4] = 1'b1;
    rst_n = 1'b0;
    #1;
    check("mid reset uio_out", int'(uio_out), 0);
    read_result(q, r);
    check("mid reset q", int'(q), 0);
    check("mid reset r", int'(r), 0);
    #2 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("held start no launch", int'(uio_out), 0);
    uio_in[4] = 1'b0;
    tick();
    full_div("after reset", 8'd77, 4'd6, 8'd12, 4'd5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
